// File: rtl/wb_queue_pkg.sv
// Shared definitions for the write-back queue: regfile address width, default
// sizes and the active-low write-enable encoding.
package wb_queue_pkg;
    localparam int   REG_W      = 3;
    localparam int   DATA_W_DEF = 16;
    localparam int   WB_DEPTH   = 4;
    localparam logic ENABLE_    = 1'b0;
    localparam logic DISABLE_   = 1'b1;
endpackage

// File: rtl/wb_queue_if.sv
// Bundle of the write-back queue's memory-stage, regfile and decode-bypass signals.
// master = the surrounding pipeline, slave = the queue.
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_dstE;
    logic [REG_W-1:0]  in_dstM;
    logic [DATA_W-1:0] in_valE;
    logic [DATA_W-1:0] in_valM;
    logic              wb_hold;
    logic [REG_W-1:0]  rf_dstE;
    logic [REG_W-1:0]  rf_dstM;
    logic [DATA_W-1:0] rf_valE;
    logic [DATA_W-1:0] rf_valM;
    logic              rf_we_;
    logic [REG_W-1:0]  qA;
    logic [REG_W-1:0]  qB;
    logic              fwdA_hit;
    logic              fwdB_hit;
    logic [DATA_W-1:0] fwdA_val;
    logic [DATA_W-1:0] fwdB_val;
    logic [7:0]        pend;
    logic              empty;

    modport master (
        output in_valid, in_dstE, in_dstM, in_valE, in_valM, wb_hold, qA, qB,
        input  in_ready, rf_dstE, rf_dstM, rf_valE, rf_valM, rf_we_,
               fwdA_hit, fwdB_hit, fwdA_val, fwdB_val, pend, empty
    );

    modport slave (
        input  in_valid, in_dstE, in_dstM, in_valE, in_valM, wb_hold, qA, qB,
        output in_ready, rf_dstE, rf_dstM, rf_valE, rf_valM, rf_we_,
               fwdA_hit, fwdB_hit, fwdA_val, fwdB_val, pend, empty
    );
endinterface

// File: rtl/wb_queue_fifo.sv
// Circular in-order store. Entries are presented oldest-first (index 0 = head)
// together with a per-entry valid vector so the owner can scan by age.
module wb_queue_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              push_data,
    output logic [DEPTH-1:0][W-1:0]   age_data,
    output logic [DEPTH-1:0]          age_valid,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    ptr_t       rd_ptr_q, rd_ptr_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    cnt_t       count_q, count_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic       do_push, do_pop;

    assign full    = (count_q == cnt_t'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_data[gi]  = mem_q[rd_ptr_q + ptr_t'(gi)];
            assign age_valid[gi] = (cnt_t'(gi) < count_q);
        end
    endgenerate
endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers memory-stage results, drains one per cycle into the
// regfile, and offers a pending-write scoreboard plus youngest-entry bypass.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    wb_queue_if.slave  bus
);
    localparam int ENT_W = 2 * REG_W + 2 * DATA_W;

    logic [DEPTH-1:0][ENT_W-1:0] age_data;
    logic [DEPTH-1:0]            age_valid;
    logic [DEPTH-1:0]            ent_valid;
    logic                        full, fifo_empty;
    logic                        push, pop;
    logic [REG_W-1:0]            dst_e [DEPTH];
    logic [REG_W-1:0]            dst_m [DEPTH];
    logic [DATA_W-1:0]           val_e [DEPTH];
    logic [DATA_W-1:0]           val_m [DEPTH];
    logic [REG_W-1:0]            q_sel [2];
    logic                        hit   [2];
    logic [DATA_W-1:0]           hval  [2];
    logic [7:0]                  pend_v;

    // While reset is high the queue already looks empty, so nothing drains on the reset edge.
    assign ent_valid = age_valid & {DEPTH{~reset}};
    assign push      = bus.in_valid && !full && !reset;
    assign pop       = !fifo_empty && !bus.wb_hold && !reset;

    wb_queue_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data ({bus.in_dstE, bus.in_dstM, bus.in_valE, bus.in_valM}),
        .age_data  (age_data),
        .age_valid (age_valid),
        .full      (full),
        .empty     (fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign dst_e[gi] = age_data[gi][ENT_W-1 -: REG_W];
            assign dst_m[gi] = age_data[gi][ENT_W-REG_W-1 -: REG_W];
            assign val_e[gi] = age_data[gi][2*DATA_W-1 -: DATA_W];
            assign val_m[gi] = age_data[gi][DATA_W-1:0];
        end
    endgenerate

    assign bus.in_ready = reset || !full;
    assign bus.empty    = reset || fifo_empty;
    assign bus.rf_dstE  = dst_e[0];
    assign bus.rf_dstM  = dst_m[0];
    assign bus.rf_valE  = val_e[0];
    assign bus.rf_valM  = val_m[0];
    assign bus.rf_we_   = (pop && (dst_e[0] != '0 || dst_m[0] != '0)) ? ENABLE_ : DISABLE_;

    always_comb begin
        pend_v = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k]) begin
                pend_v[dst_e[k]] = 1'b1;
                pend_v[dst_m[k]] = 1'b1;
            end
        end
        pend_v[0] = 1'b0;
    end
    assign bus.pend = pend_v;

    assign q_sel[0] = bus.qA;
    assign q_sel[1] = bus.qB;

    // Scan oldest to youngest so the youngest matching entry is the one left standing.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byp
            always_comb begin
                hit[gi]  = 1'b0;
                hval[gi] = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (ent_valid[k] && q_sel[gi] != '0 &&
                        (dst_e[k] == q_sel[gi] || dst_m[k] == q_sel[gi])) begin
                        hit[gi]  = 1'b1;
                        hval[gi] = (dst_m[k] == q_sel[gi]) ? val_m[k] : val_e[k];
                    end
                end
            end
        end
    endgenerate

    assign bus.fwdA_hit = hit[0];
    assign bus.fwdB_hit = hit[1];
    assign bus.fwdA_val = hval[0];
    assign bus.fwdB_val = hval[1];
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back side of the register file: accepts completed instruction results (dstE/valE, dstM/valM) from the memory stage.
- Buffers them in a small in-order queue and drives the register file write port (dstE, dstM, valE, valM, we_) one entry per cycle.
- Exports a pending-write scoreboard and a youngest-entry bypass so decode can detect and resolve read-after-write hazards on values not yet written.

Parameters:
- DATA_W, 16, data width; equals the `DataBus width.
- DEPTH, 4, queue entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage presents a result.
- in_ready  out  1  queue can accept; transfer when in_valid && in_ready.
- in_dstE  in  3  E-result register (0 = none).
- in_dstM  in  3  M-result register (0 = none).
- in_valE  in  DATA_W  ALU result.
- in_valM  in  DATA_W  memory read result.
- wb_hold  in  1  stall controller freezes draining.
- rf_dstE  out  3  to regfile dstE.
- rf_dstM  out  3  to regfile dstM.
- rf_valE  out  DATA_W  to regfile valE.
- rf_valM  out  DATA_W  to regfile valM.
- rf_we_  out  1  regfile write enable, active-low (`ENABLE_ = 0).
- qA, qB  in  3  decode-stage source register queries.
- fwdA_hit, fwdB_hit  out  1  queried register has a queued write.
- fwdA_val, fwdB_val  out  DATA_W  value that write will deposit.
- pend  out  8  bit r set when any queued entry targets r; bit 0 always 0.
- empty  out  1  queue empty.

Behaviour:
- Reset (sync, high): rd_ptr = wr_ptr = 0, count = 0, all entries discarded. Reset mid-operation drops queued writes; no regfile write occurs on the reset edge.
- Outputs during and after reset: rf_we_ = 1, in_ready = 1, empty = 1, pend = 0, fwd*_hit = 0. rf_dst*/rf_val* are driven from the head entry and are don't-care while rf_we_ = 1.
- Storage: circular buffer, entry = {dstE, dstM, valE, valM}. Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- in_ready = (count != DEPTH), registered-state only. No same-cycle pass-through when full.
- in_valid while !in_ready is ignored. Upstream holds its data stable.
- Push at edge when in_valid && in_ready: entry written at wr_ptr, wr_ptr++.
- Pop condition: !empty && !wb_hold. On the pop edge the regfile samples the head and rd_ptr++.
- Simultaneous push and pop: count unchanged.
- rf_* outputs are combinational from the head entry.
- rf_we_ = 0 only when the pop condition holds and (head dstE != 0 or head dstM != 0). An entry with both dst = 0 is still popped but with rf_we_ = 1.
- Latency: entry pushed at edge N into an empty queue is written to the regfile at edge N+1, absent hold.
- wb_hold = 1: rf_we_ = 1, no pop; pushes continue until full.
- pend[r], r = 1..7: OR over valid entries of (dstE == r) or (dstM == r). Combinational, reflects registered state only.
- Bypass for qX: scan valid entries from youngest to oldest; the first entry with dstM == qX or dstE == qX hits.
  - Within that entry valM wins when dstM == qX. This matches regfile priority, which ignores dstE when dstE == dstM.
  - qX = 0 never hits; fwdX_val = 0 on a miss.
  - The incoming in_* result is not considered: no combinational path from in_* to fwd*.
- The head entry being written this cycle still hits. The regfile updates only at the edge.

Decomposition:
- Shared header minicpu.h: `ENABLE_/`DISABLE_, `DataBus, register address width (3), WB_DEPTH default.
- Sub-module wb_fifo: circular storage, pointers, count, full/empty; exposes all entries plus a per-entry valid vector.
- Top level wb_queue: handshake, rf_we_ gating, scoreboard, and the priority bypass scan.

Test Plan:
- Reset, then push {dstE=3, valE=0x1234, dstM=0}: rf_we_ = 0 at the next edge with rf_dstE = 3; pend[3] is 1 for exactly one cycle, then empty = 1.
- Hold and age order: wb_hold = 1, push r2 = 0x0011 then r2 = 0x0022. Query qA = 2 → hit, val 0x0022; pend = 0x04; release hold → two writes in order, 0x0011 then 0x0022.
- Same-register priority: push {dstE=5, dstM=5, valE=0xAAAA, valM=0x5555}, query 5 → fwd = 0x5555; regfile receives dstM = 5.
- Full queue: hold, push DEPTH entries → in_ready = 0; an extra in_valid pulse is dropped. Release → exactly DEPTH writes, pointers wrap, and a following push/pop pair works.
- Null and zero-register cases: push {0, 0} → popped with rf_we_ = 1; query qA = 0 → no hit, 0.
- Mid-operation reset: 3 entries queued under hold, assert reset → count = 0, pend = 0; no regfile write after release.
